// File: rtl/mysystem_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the correlator (A)
// and the host/DMA side (B), with an atomic read-add-write accumulate for A.
module mysystem_ram_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  a_req,
  input  logic [1:0]            a_op,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_W-1:0]     a_rdata,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  busy,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam logic [1:0]  OP_WRITE = 2'b01;
  localparam logic [1:0]  OP_ACC   = 2'b10;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    ACC_WAIT = 2'd1,
    ACC_WB   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                prio_b;       // 1: B wins a tie (A was granted last)
  logic                prio_b_nxt;
  logic                a_is_write;
  logic                a_is_acc;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_addend;
  logic [DATA_W-1:0]   sum;
  logic [ADDR_W-1:0]   addr_hold;
  logic [BE_W-1:0]     be_hold;
  logic [DATA_W-1:0]   wdata_hold;
  logic                tag_v;
  logic                tag_b;

  assign a_is_write = (a_op == OP_WRITE);
  assign a_is_acc   = (a_op == OP_ACC);
  assign ram_clken  = 1'b1;

  // State and round-robin priority registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ARB;
      prio_b <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      prio_b <= prio_b_nxt;
      busy   <= (state_nxt != ARB);
    end
  end

  // Arbitration, next state and RAM command mux
  always_comb begin
    state_nxt      = state;
    prio_b_nxt     = prio_b;
    a_gnt          = 1'b0;
    b_gnt          = 1'b0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_address    = addr_hold;
    ram_byteenable = be_hold;
    ram_writedata  = wdata_hold;
    case (state)
      ARB: begin
        if (en) begin
          if (a_req && (!b_req || !prio_b)) begin
            a_gnt          = 1'b1;
            prio_b_nxt     = 1'b1;
            ram_chipselect = 1'b1;
            ram_write      = a_is_write;
            ram_address    = a_addr;
            ram_byteenable = a_is_acc ? {BE_W{1'b1}} : a_be;
            ram_writedata  = a_wdata;
            if (a_is_acc) begin
              state_nxt = ACC_WAIT;
            end
          end else if (b_req) begin
            b_gnt          = 1'b1;
            prio_b_nxt     = 1'b0;
            ram_chipselect = 1'b1;
            ram_write      = b_we;
            ram_address    = b_addr;
            ram_byteenable = b_be;
            ram_writedata  = b_wdata;
          end
        end
      end
      ACC_WAIT: begin
        state_nxt = ACC_WB;
      end
      ACC_WB: begin
        ram_chipselect = 1'b1;
        ram_write      = 1'b1;
        ram_address    = acc_addr;
        ram_byteenable = {BE_W{1'b1}};
        ram_writedata  = sum;
        state_nxt      = ARB;
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
    // Nothing may reach the RAM or a requester while reset is asserted
    if (!reset_n) begin
      a_gnt          = 1'b0;
      b_gnt          = 1'b0;
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
    end
  end

  // Hold address/byteenable/writedata when no command is driven
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_hold  <= '0;
      be_hold    <= '0;
      wdata_hold <= '0;
    end else begin
      addr_hold  <= ram_address;
      be_hold    <= ram_byteenable;
      wdata_hold <= ram_writedata;
    end
  end

  // Accumulate operand capture and sum formation
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_addr   <= '0;
      acc_addend <= '0;
      sum        <= '0;
    end else begin
      if (a_gnt && a_is_acc) begin
        acc_addr   <= a_addr;
        acc_addend <= a_wdata;
      end
      if (state == ACC_WAIT) begin
        sum <= DATA_W'(ram_readdata + acc_addend);
      end
    end
  end

  // Read return: tag follows each granted read, data lands one cycle later
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_v    <= 1'b0;
      tag_b    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      tag_v    <= (a_gnt && !a_is_write && !a_is_acc) || (b_gnt && !b_we);
      tag_b    <= b_gnt;
      a_rvalid <= tag_v && !tag_b;
      b_rvalid <= tag_v && tag_b;
      if (tag_v && !tag_b) begin
        a_rdata <= ram_readdata;
      end
      if (tag_v && tag_b) begin
        b_rdata <= ram_readdata;
      end
    end
  end

endmodule

// File: tb/tb_mysystem_ram_arbiter.sv
// Bench for mysystem_ram_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the shared RAM and the arbiter rules.
module tb_mysystem_ram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        a_req;
  logic [1:0]  a_op;
  logic [11:0] a_addr;
  logic [3:0]  a_be;
  logic [31:0] a_wdata;
  logic        b_req;
  logic        b_we;
  logic [11:0] b_addr;
  logic [3:0]  b_be;
  logic [31:0] b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
  logic [31:0] a_rdata, b_rdata;
  logic [11:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram_mem [0:4095];

  mysystem_ram_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .busy(busy),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with byte enables and a registered output
  always @(posedge clk) begin
    if (ram_chipselect && ram_write) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_byteenable[i]) ram_mem[ram_address][i*8 +: 8] <= ram_writedata[i*8 +: 8];
      end
    end
    ram_readdata <= ram_mem[ram_address];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; a_req = 1'b0; b_req = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Preload one RAM word through port B (arbiter must be idle)
  task automatic b_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    a_req = 1'b0; en = 1'b1;
    b_req = 1'b1; b_we = 1'b1; b_addr = addr; b_be = 4'hF; b_wdata = data;
    @(negedge clk);
    b_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; en = 1'b1;
    a_req = 1'b1; a_op = 2'b01; a_addr = 12'h005; a_be = 4'hF; a_wdata = 32'h1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h006; b_be = 4'hF; b_wdata = 32'h2;
    #1;
    n_tests++; if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_a_gnt: got %b want 0", a_gnt); end
    n_tests++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_b_gnt: got %b want 0", b_gnt); end
    n_tests++; if (ram_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs: got %b want 0", ram_chipselect); end
    n_tests++; if (ram_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b want 0", ram_write); end
    @(negedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {a_rvalid, b_rvalid}); end
    n_tests++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_a_rdata: got %h want 0", a_rdata); end
    n_tests++; if (b_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_b_rdata: got %h want 0", b_rdata); end
    n_tests++; if (ram_clken !== 1'b1) begin n_fail++; $display("FAIL rst_clken: got %b want 1", ram_clken); end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    // Full write then read-back next cycle
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h010; b_be = 4'hF; b_wdata = 32'hDEADBEEF; #1;
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b want 1", b_gnt); end
    n_tests++; if ({ram_chipselect, ram_write} !== 2'b11) begin n_fail++; $display("FAIL wr_cmd: got %b want 11", {ram_chipselect, ram_write}); end
    n_tests++; if (ram_address !== 12'h010) begin n_fail++; $display("FAIL wr_addr: got %h want 010", ram_address); end
    @(negedge clk);
    b_we = 1'b0; #1;
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", b_gnt); end
    n_tests++; if (ram_write !== 1'b0) begin n_fail++; $display("FAIL rd_write: got %b want 0", ram_write); end
    @(negedge clk);
    b_req = 1'b0; #1;
    n_tests++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_early: got %b want 0", b_rvalid); end
    @(negedge clk); #1;
    n_tests++; if (b_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %b want 1", b_rvalid); end
    n_tests++; if (b_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", b_rdata); end
    // Partial write over the same word
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_be = 4'b0011; b_wdata = 32'h11223344; #1;
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL pw_gnt: got %b want 1", b_gnt); end
    @(negedge clk);
    b_we = 1'b0;
    @(negedge clk);
    b_req = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (b_rvalid !== 1'b1) begin n_fail++; $display("FAIL pw_rvalid: got %b want 1", b_rvalid); end
    n_tests++; if (b_rdata !== 32'hDEAD3344) begin n_fail++; $display("FAIL pw_data: got %h want dead3344", b_rdata); end
  endtask

  task automatic test_round_robin();
    b_write(12'h001, 32'hA1A1A1A1);
    b_write(12'h002, 32'hB2B2B2B2);
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      logic exp_a;
      @(negedge clk);
      a_req = 1'b1; a_op = 2'b00; a_addr = 12'h001;
      b_req = 1'b1; b_we = 1'b0; b_addr = 12'h002;
      #1;
      exp_a = (k % 2 == 0);
      n_tests++; if ({a_gnt, b_gnt} !== {exp_a, !exp_a}) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, {a_gnt, b_gnt}, {exp_a, !exp_a}); end
      if (k >= 2) begin
        n_tests++; if ({a_rvalid, b_rvalid} !== {exp_a, !exp_a}) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, {a_rvalid, b_rvalid}, {exp_a, !exp_a}); end
        n_tests++;
        if (exp_a && a_rdata !== 32'hA1A1A1A1) begin n_fail++; $display("FAIL rr_a_data[%0d]: got %h want a1a1a1a1", k, a_rdata); end
        else if (!exp_a && b_rdata !== 32'hB2B2B2B2) begin n_fail++; $display("FAIL rr_b_data[%0d]: got %h want b2b2b2b2", k, b_rdata); end
      end else begin
        n_tests++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want 00", k, {a_rvalid, b_rvalid}); end
      end
    end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_accumulate();
    b_write(12'h020, 32'hFFFFFFF0);
    apply_reset();
    @(negedge clk);
    a_req = 1'b1; a_op = 2'b10; a_addr = 12'h020; a_be = 4'h0; a_wdata = 32'h20;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h002; #1;
    n_tests++; if ({a_gnt, b_gnt} !== 2'b10) begin n_fail++; $display("FAIL acc_gnt: got %b want 10", {a_gnt, b_gnt}); end
    n_tests++; if ({ram_chipselect, ram_write} !== 2'b10) begin n_fail++; $display("FAIL acc_rdcmd: got %b want 10", {ram_chipselect, ram_write}); end
    @(negedge clk);
    a_req = 1'b0; #1;
    n_tests++; if ({a_gnt, b_gnt} !== 2'b00) begin n_fail++; $display("FAIL acc_wait_gnt: got %b want 00", {a_gnt, b_gnt}); end
    n_tests++; if ({busy, ram_chipselect} !== 2'b10) begin n_fail++; $display("FAIL acc_wait_busy_cs: got %b want 10", {busy, ram_chipselect}); end
    @(negedge clk); #1;
    n_tests++; if ({a_gnt, b_gnt} !== 2'b00) begin n_fail++; $display("FAIL acc_wb_gnt: got %b want 00", {a_gnt, b_gnt}); end
    n_tests++; if ({busy, ram_chipselect, ram_write} !== 3'b111) begin n_fail++; $display("FAIL acc_wb_cmd: got %b want 111", {busy, ram_chipselect, ram_write}); end
    n_tests++; if ({ram_address, ram_byteenable, ram_writedata} !== {12'h020, 4'hF, 32'h00000010}) begin n_fail++; $display("FAIL acc_wb_bus: got %h/%h/%h want 020/f/00000010", ram_address, ram_byteenable, ram_writedata); end
    n_tests++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL acc_rvalid_wb: got %b want 0", a_rvalid); end
    @(negedge clk); #1;
    n_tests++; if ({a_gnt, b_gnt, busy} !== 3'b010) begin n_fail++; $display("FAIL acc_next_gnt: got %b want 010", {a_gnt, b_gnt, busy}); end
    n_tests++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL acc_rvalid_after: got %b want 0", a_rvalid); end
    @(negedge clk);
    b_addr = 12'h020; #1;
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL acc_rb_gnt: got %b want 1", b_gnt); end
    @(negedge clk);
    b_req = 1'b0; #1;
    n_tests++; if ({b_rvalid, b_rdata} !== {1'b1, 32'hB2B2B2B2}) begin n_fail++; $display("FAIL acc_b_rd1: got %b/%h want 1/b2b2b2b2", b_rvalid, b_rdata); end
    @(negedge clk); #1;
    n_tests++; if ({b_rvalid, b_rdata} !== {1'b1, 32'h00000010}) begin n_fail++; $display("FAIL acc_result: got %b/%h want 1/00000010", b_rvalid, b_rdata); end
  endtask

  task automatic test_acc_reset();
    b_write(12'h020, 32'hFFFFFFF0);
    apply_reset();
    @(negedge clk);
    a_req = 1'b1; a_op = 2'b10; a_addr = 12'h020; a_wdata = 32'h20; b_req = 1'b0; #1;
    n_tests++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL accr_gnt: got %b want 1", a_gnt); end
    @(negedge clk);
    a_req = 1'b0; reset_n = 1'b0; #1;
    n_tests++; if (ram_write !== 1'b0) begin n_fail++; $display("FAIL accr_rst_write: got %b want 0", ram_write); end
    @(negedge clk);
    reset_n = 1'b1;
    a_req = 1'b1; a_op = 2'b00; a_addr = 12'h020;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'h002; #1;
    n_tests++; if (ram_write !== 1'b0) begin n_fail++; $display("FAIL accr_no_wb: got %b want 0", ram_write); end
    n_tests++; if ({a_gnt, b_gnt, busy} !== 3'b100) begin n_fail++; $display("FAIL accr_first_gnt: got %b want 100", {a_gnt, b_gnt, busy}); end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk); #1;
    n_tests++; if ({a_rvalid, a_rdata} !== {1'b1, 32'hFFFFFFF0}) begin n_fail++; $display("FAIL accr_unmodified: got %b/%h want 1/fffffff0", a_rvalid, a_rdata); end
  endtask

  task automatic test_enable();
    apply_reset();
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 12'h002; #1;
    n_tests++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL en_b_gnt: got %b want 1", b_gnt); end
    @(negedge clk);
    en = 1'b0; a_req = 1'b1; a_op = 2'b00; a_addr = 12'h001; #1;
    n_tests++; if ({a_gnt, b_gnt} !== 2'b00) begin n_fail++; $display("FAIL en_off_gnt1: got %b want 00", {a_gnt, b_gnt}); end
    @(negedge clk); #1;
    n_tests++; if ({b_rvalid, b_rdata} !== {1'b1, 32'hB2B2B2B2}) begin n_fail++; $display("FAIL en_off_rvalid: got %b/%h want 1/b2b2b2b2", b_rvalid, b_rdata); end
    n_tests++; if ({a_gnt, b_gnt} !== 2'b00) begin n_fail++; $display("FAIL en_off_gnt2: got %b want 00", {a_gnt, b_gnt}); end
    @(negedge clk); #1;
    n_tests++; if ({a_gnt, b_gnt, ram_chipselect} !== 3'b000) begin n_fail++; $display("FAIL en_off_gnt3: got %b want 000", {a_gnt, b_gnt, ram_chipselect}); end
    @(negedge clk);
    en = 1'b1; #1;
    n_tests++; if ({a_gnt, b_gnt} !== 2'b10) begin n_fail++; $display("FAIL en_on_gnt: got %b want 10", {a_gnt, b_gnt}); end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
  endtask

  typedef struct {
    int          cyc;
    bit          port_b;
    logic [31:0] data;
  } ret_t;

  task automatic test_random();
    logic [31:0] mm [0:7];
    ret_t        rq [$];
    bit          a_pend, b_pend, a_first, exp_a, exp_b, exp_av, exp_bv, exp_cs, exp_wr;
    int          free_cyc, wb_cyc, idx;
    logic [31:0] last_a, last_b;
    for (int i = 0; i < 8; i++) begin
      mm[i] = $urandom;
      b_write(12'h100 + 12'(i), mm[i]);
    end
    apply_reset();
    a_pend = 0; b_pend = 0; a_first = 1; free_cyc = 0; wb_cyc = -1;
    last_a = 32'h0; last_b = 32'h0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (!a_pend && $urandom_range(0, 3) != 0) begin
        a_pend = 1; a_op = 2'($urandom_range(0, 3));
        a_addr = 12'h100 + 12'($urandom_range(0, 7));
        a_be = 4'($urandom); a_wdata = 32'($urandom);
      end
      if (!b_pend && $urandom_range(0, 3) != 0) begin
        b_pend = 1; b_we = 1'($urandom_range(0, 1));
        b_addr = 12'h100 + 12'($urandom_range(0, 7));
        b_be = 4'($urandom); b_wdata = 32'($urandom);
      end
      a_req = a_pend; b_req = b_pend;
      en = ($urandom_range(0, 7) != 0);
      #1;
      exp_a  = en && (c >= free_cyc) && a_pend && (!b_pend || a_first);
      exp_b  = en && (c >= free_cyc) && b_pend && !exp_a;
      exp_cs = exp_a || exp_b || (c == wb_cyc);
      exp_wr = (exp_a && a_op == 2'b01) || (exp_b && b_we) || (c == wb_cyc);
      n_tests++; if ({a_gnt, b_gnt} !== {exp_a, exp_b}) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, {a_gnt, b_gnt}, {exp_a, exp_b}); end
      n_tests++; if (busy !== (c < free_cyc)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", c, busy, (c < free_cyc)); end
      n_tests++; if ({ram_chipselect, ram_write} !== {exp_cs, exp_wr}) begin n_fail++; $display("FAIL rnd_ramcmd@%0d: got %b want %b", c, {ram_chipselect, ram_write}, {exp_cs, exp_wr}); end
      exp_av = 0; exp_bv = 0;
      if (rq.size() > 0 && rq[0].cyc == c) begin
        if (rq[0].port_b) begin exp_bv = 1; last_b = rq[0].data; end
        else begin exp_av = 1; last_a = rq[0].data; end
        void'(rq.pop_front());
      end
      n_tests++; if ({a_rvalid, b_rvalid} !== {exp_av, exp_bv}) begin n_fail++; $display("FAIL rnd_rvalid@%0d: got %b want %b", c, {a_rvalid, b_rvalid}, {exp_av, exp_bv}); end
      n_tests++; if ({a_rdata, b_rdata} !== {last_a, last_b}) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h/%h want %h/%h", c, a_rdata, b_rdata, last_a, last_b); end
      // Apply the granted transaction to the memory model
      if (exp_a) begin
        idx = int'(a_addr[2:0]);
        if (a_op == 2'b01) begin
          for (int j = 0; j < 4; j++) if (a_be[j]) mm[idx][j*8 +: 8] = a_wdata[j*8 +: 8];
        end else if (a_op == 2'b10) begin
          mm[idx] = mm[idx] + a_wdata;
          free_cyc = c + 3; wb_cyc = c + 2;
        end else begin
          rq.push_back('{cyc: c + 2, port_b: 1'b0, data: mm[idx]});
        end
        a_first = 0; a_pend = 0;
      end else if (exp_b) begin
        idx = int'(b_addr[2:0]);
        if (b_we) begin
          for (int j = 0; j < 4; j++) if (b_be[j]) mm[idx][j*8 +: 8] = b_wdata[j*8 +: 8];
        end else begin
          rq.push_back('{cyc: c + 2, port_b: 1'b1, data: mm[idx]});
        end
        a_first = 1; b_pend = 0;
      end
    end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0; en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1;
    a_req = 1'b0; a_op = 2'b00; a_addr = '0; a_be = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_accumulate();
    test_acc_reset();
    test_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
